exec_stage: RTL
===============

# exec_stage

Execute stage sitting directly downstream of the register file: it takes operand A from the register file's read port, operand B from the r1 copy register, an operation code and a destination address, and computes the result. Single-cycle logic ops and multi-cycle iterative shifts (optionally multiply) run under a small FSM. Each result goes back to the register file as a one-cycle write strobe, along with Zero and Carry flags for branch logic.

## Interface
- W, 8, data path width
- A, 4, register address width
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears all state and outputs
- InValid  input  1  operation request valid
- InReady  output  1  stage can accept a request this cycle
- InOp  input  4  operation code (see Operation)
- InA  input  W  operand A (register file DataOutA)
- InB  input  W  operand B (r1)
- InWaddr  input  A  destination register for the result
- WriteEn  output  1  one-cycle write strobe to the register file
- Waddr  output  A  destination register, valid while WriteEn=1
- DataOut  output  W  result, valid while WriteEn=1, held afterwards
- Zero  output  1  result==0, updated with each WriteEn
- Carry  output  1  carry/borrow/shift-out/overflow, updated with each WriteEn
- IllegalOp  output  1  one-cycle pulse when an unsupported code is accepted

## Operation
- Opcodes:
  - 0 ADD: A+B; Carry=bit W.
  - 1 SUB: A-B computed as A+~B+1; Carry=1 means no borrow (A>=B).
  - 2 AND, 3 OR, 4 XOR, 8 PASS (=A): Carry=0.
  - 5 SHL, 6 SHR: logical shifts; amount k=min(B[3:0],8); Carry=last bit shifted out, 0 if k=0.
  - 7 MUL: see Configuration.
  - 9-15: illegal.
- Accept: an edge where InValid=1 and InReady=1; InA, InB, InOp and InWaddr are captured on that edge.
- FSM states IDLE, RUN, WB.
  - IDLE/WB + accept of a single-cycle op → WB.
  - IDLE/WB + accept of a shift with k>0, or of MUL → RUN.
  - IDLE/WB + accept of a shift with k=0 → WB, with result=A.
  - IDLE/WB + accept of an illegal op → IDLE; IllegalOp pulses for 1 cycle; no WriteEn.
  - RUN: one bit per cycle; the count decrements; count reaching 0 → WB.
  - WB with no accept → IDLE.
- InReady=1 in IDLE and WB, 0 in RUN. Back-to-back single-cycle ops can issue every cycle.
- WriteEn=1 exactly in WB cycles. Waddr, DataOut, Zero and Carry are registered and hold their value until the next WB.
- Arithmetic is modulo 2^W; no sign handling.
- Reset while RUN: the operation is abandoned immediately; no WriteEn is produced.
- Reset values: InReady=0 while Reset is asserted, 1 after release (IDLE). WriteEn=0, Waddr=0, DataOut=0, Zero=0, Carry=0, IllegalOp=0.

## Timing
- Single-cycle op accepted at edge N: WriteEn is high in the cycle after edge N, i.e. latency 1.
- Shift accepted at edge N with k>0: RUN for k cycles, then WB; WriteEn rises k+1 cycles after N. Maximum latency is 9 (k=8).
- MUL (when enabled): exactly 8 RUN cycles; WriteEn rises 9 cycles after accept.
- An accept in WB overlaps the current writeback. The new result appears in the next cycle(s); the current WB data is not disturbed.
- Outputs are driven only from registers; there is no combinational path from inputs to WriteEn, DataOut or flags. InReady is decoded from the state register.

## Configuration
- EXEC_MUL_EN defined: opcode 7 is an iterative shift-add multiply of A×B over 8 RUN cycles. DataOut = low W bits of the product; Carry = OR of the high W bits (overflow); Zero reflects the low W bits.
- EXEC_MUL_EN undefined: opcode 7 is illegal (IllegalOp pulse, no WriteEn), and no multiplier datapath is built.

## Test plan
- Reset mid-op:
  - Stimulus: accept SHL A=0x01, B=0x05; assert Reset 2 cycles later.
  - Required: all outputs 0 immediately; no WriteEn ever; InReady=1 after release.
- Back-to-back writes:
  - Stimulus: ADD 0xF0+0x20 to r4, then SUB 0x10-0x10 to r5 on consecutive cycles.
  - Required: WriteEn 2 consecutive cycles; first 0x10/Waddr=4/Carry=1/Zero=0; second 0x00/Waddr=5/Carry=1/Zero=1.
- Shift latency and clamp:
  - Stimulus: SHR A=0x81, B=0x03 → DataOut 0x10, Carry=0, WriteEn 4 cycles after accept. SHL A=0xFF, B=0x0F.
  - Required (SHL): clamped to 8; DataOut 0x00, Zero=1, Carry=1, latency 9; InReady=0 throughout RUN.
- Illegal op:
  - Stimulus: opcode 12.
  - Required: IllegalOp high one cycle; WriteEn stays 0; DataOut/flags keep previous values.
- MUL with EXEC_MUL_EN:
  - Stimulus: 0x12×0x10.
  - Required: DataOut 0x20, Carry=1, latency 9.
- MUL without EXEC_MUL_EN:
  - Stimulus: same op.
  - Required: IllegalOp pulse; no write.
- Shift of zero:
  - Stimulus: SHL A=0x5A, B=0x00.
  - Required: DataOut 0x5A, Carry=0, latency 1.

Source files
------------

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: single-cycle ALU ops plus iterative shifts/multiply under a small FSM
// Optional feature: define EXEC_MUL_EN to build the opcode-7 shift-add multiplier.
module exec_stage #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   in_op_i,
  input  logic [W-1:0] in_a_i,
  input  logic [W-1:0] in_b_i,
  input  logic [A-1:0] in_waddr_i,
  output logic         write_en_o,
  output logic [A-1:0] waddr_o,
  output logic [W-1:0] data_out_o,
  output logic         zero_o,
  output logic         carry_o,
  output logic         illegal_op_o
);

  localparam int CW = (W > 8) ? $clog2(W + 1) : 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q;
  logic [W-1:0]   sh_q;
  logic [CW-1:0]  cnt_q;
  logic [A-1:0]   waddr_pend_q;
  logic [A-1:0]   waddr_q;
  logic [W-1:0]   data_q;
  logic           zero_q;
  logic           carry_q;
  logic           illegal_q;

  logic           accept;
  logic [3:0]     shamt;
  logic           op_is_shift;
  logic           op_is_mul;
  logic           op_illegal;
  logic           op_multi;
  logic [W:0]     sum_ext;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic [W-1:0]   sh_next;
  logic           sh_c;
  logic [W-1:0]   run_res;
  logic           run_c;
  logic           run_last;

  // Request decode; shift distance saturates at 8 bits
  assign accept      = in_valid_i && in_ready_o;
  assign shamt       = (in_b_i[3:0] > 4'd8) ? 4'd8 : in_b_i[3:0];
  assign op_is_shift = (in_op_i == OP_SHL) || (in_op_i == OP_SHR);
  assign op_illegal  = (in_op_i > OP_PASS) || ((in_op_i == OP_MUL) && !op_is_mul);
  assign op_multi    = (op_is_shift && (shamt != 4'd0)) || op_is_mul;
  assign run_last    = (cnt_q == CW'(1));

`ifdef EXEC_MUL_EN
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mc_q;
  logic [W-1:0]   mb_q;
  logic [2*W-1:0] acc_step;

  assign op_is_mul = (in_op_i == OP_MUL);
  assign acc_step  = mb_q[0] ? (acc_q + mc_q) : acc_q;

  // One multiplier bit per RUN cycle: add the shifted multiplicand when the bit is set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      mc_q  <= '0;
      mb_q  <= '0;
    end else if (accept && op_is_mul) begin
      acc_q <= '0;
      mc_q  <= {{W{1'b0}}, in_a_i};
      mb_q  <= in_b_i;
    end else if (state_q == S_RUN) begin
      acc_q <= acc_step;
      mc_q  <= mc_q << 1;
      mb_q  <= mb_q >> 1;
    end
  end
`else
  assign op_is_mul = 1'b0;
`endif

  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (in_op_i)
      OP_ADD: begin
        sum_ext = {1'b0, in_a_i} + {1'b0, in_b_i};
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
      end
      OP_SUB: begin
        sum_ext = {1'b0, in_a_i} + {1'b0, ~in_b_i} + {{W{1'b0}}, 1'b1};
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
      end
      OP_AND:  alu_res = in_a_i & in_b_i;
      OP_OR:   alu_res = in_a_i | in_b_i;
      OP_XOR:  alu_res = in_a_i ^ in_b_i;
      OP_SHL, OP_SHR, OP_PASS: alu_res = in_a_i;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    sh_next = sh_q << 1;
    sh_c    = sh_q[W-1];
    if (op_q == OP_SHR) begin
      sh_next = sh_q >> 1;
      sh_c    = sh_q[0];
    end
  end

  always_comb begin
    run_res = sh_next;
    run_c   = sh_c;
`ifdef EXEC_MUL_EN
    if (op_q == OP_MUL) begin
      run_res = acc_step[W-1:0];
      run_c   = |acc_step[2*W-1:W];
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (run_last) begin
          state_d = S_WB;
        end
      end
      default: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (op_illegal) begin
          state_d = S_IDLE;
        end else if (op_multi) begin
          state_d = S_RUN;
        end else begin
          state_d = S_WB;
        end
      end
    endcase
  end

  always_comb begin
    in_ready_o = (state_q != S_RUN) && !rst_i;
    write_en_o = (state_q == S_WB);
  end

  // Result registers change only on the edge that enters WB, so an overlapping accept
  // never disturbs the writeback currently on the outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q         <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      waddr_pend_q <= '0;
      waddr_q      <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= accept && op_illegal;
      if (accept && !op_illegal) begin
        op_q         <= in_op_i;
        waddr_pend_q <= in_waddr_i;
        sh_q         <= in_a_i;
        cnt_q        <= op_is_mul ? CW'(W) : CW'(shamt);
        if (!op_multi) begin
          data_q  <= alu_res;
          zero_q  <= (alu_res == '0);
          carry_q <= alu_c;
          waddr_q <= in_waddr_i;
        end
      end else if (state_q == S_RUN) begin
        cnt_q <= cnt_q - CW'(1);
        sh_q  <= sh_next;
        if (run_last) begin
          data_q  <= run_res;
          zero_q  <= (run_res == '0);
          carry_q <= run_c;
          waddr_q <= waddr_pend_q;
        end
      end
    end
  end

  assign waddr_o      = waddr_q;
  assign data_out_o   = data_q;
  assign zero_o       = zero_q;
  assign carry_o      = carry_q;
  assign illegal_op_o = illegal_q;

endmodule
